// File: rtl/tdc_stream_sequencer_pkg.sv
// Shared defaults, FSM state encoding and the pixel code mapping for the
// TDC stream sequencer.
package tdc_stream_sequencer_pkg;

    localparam int unsigned DEF_NP          = 10;
    localparam int unsigned DEF_PIXEL_NUM   = 6;
    localparam int unsigned DEF_ACQ_NUM     = 4;
    localparam int unsigned DEF_NO_HIT_CODE = 0;

    // FSM state encoding
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ARM    = 2'd1;
    localparam logic [1:0] ST_STREAM = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    // Per-pixel code: no hit -> noHit; a real hit whose tof collides with the
    // no-hit code is bumped by one (saturating) so the builder can tell them apart.
    function automatic logic [31:0] mapCode(input logic        hit,
                                            input logic [31:0] tof,
                                            input logic [31:0] noHit,
                                            input logic [31:0] maxCode);
        logic [31:0] code;
        if (!hit) begin
            code = noHit;
        end else if (tof == noHit) begin
            code = (noHit == maxCode) ? maxCode : noHit + 32'd1;
        end else begin
            code = tof;
        end
        return code;
    endfunction

endpackage

// File: rtl/tdc_stream_sequencer_shot_buffer.sv
// tdc_shot_buffer: capture + stream pixel banks with occupancy flags.
// Ports: loadStream/loadCapture write shotIn into a bank; promote moves the
// capture bank into the stream bank; retire frees the stream bank; rdIdx
// selects the stream-bank pixel on rdData_c. *Nxt_c expose next-cycle flags.
module tdc_shot_buffer #(
    parameter  int unsigned NP        = 10,
    parameter  int unsigned PIXEL_NUM = 6,
    localparam int unsigned IDX_W     = (PIXEL_NUM > 1) ? $clog2(PIXEL_NUM) : 1
) (
    input  logic                    clk,
    input  logic                    res,
    input  logic                    loadStream,
    input  logic                    loadCapture,
    input  logic                    promote,
    input  logic                    retire,
    input  logic [PIXEL_NUM*NP-1:0] shotIn,
    input  logic [IDX_W-1:0]        rdIdx,
    output logic [NP-1:0]           rdData_c,
    output logic                    streamFull,
    output logic                    captureFull,
    output logic                    streamFullNxt_c,
    output logic                    captureFullNxt_c
);

    logic [NP-1:0] shotPix     [PIXEL_NUM];
    logic [NP-1:0] streamBank  [PIXEL_NUM];
    logic [NP-1:0] captureBank [PIXEL_NUM];

    // Unpack the flat shot vector into pixels
    always_comb begin
        for (int i = 0; i < PIXEL_NUM; i++) begin
            shotPix[i] = shotIn[i*NP +: NP];
        end
    end

    // Occupancy; a load or promote wins over retire in the same cycle
    always_comb begin
        streamFullNxt_c  = streamFull;
        captureFullNxt_c = captureFull;
        if (loadStream || promote) begin
            streamFullNxt_c = 1'b1;
        end else if (retire) begin
            streamFullNxt_c = 1'b0;
        end
        if (loadCapture) begin
            captureFullNxt_c = 1'b1;
        end else if (promote) begin
            captureFullNxt_c = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            streamFull  <= 1'b0;
            captureFull <= 1'b0;
        end else begin
            streamFull  <= streamFullNxt_c;
            captureFull <= captureFullNxt_c;
        end
    end

    // Bank payloads are qualified by the flags, so they need no reset
    always_ff @(posedge clk) begin
        if (promote) begin
            streamBank <= captureBank;
        end else if (loadStream) begin
            streamBank <= shotPix;
        end
        if (loadCapture) begin
            captureBank <= shotPix;
        end
    end

    assign rdData_c = streamBank[rdIdx];

endmodule

// File: rtl/tdc_stream_sequencer.sv
// tdc_stream_sequencer: captures per-pixel TDC shots and streams them one
// code per cycle (wrEn/data) to the histogram builder, ACQ_NUM shots a frame.
// Ports: start arms a frame; shot_valid/shot_ready accept a parallel shot
// (hit_vld, hit_tof); frame_done pulses after the frame; overrun flags a
// dropped shot; busy is high outside IDLE.
module tdc_stream_sequencer
    import tdc_stream_sequencer_pkg::*;
#(
    parameter int unsigned NP          = DEF_NP,
    parameter int unsigned PIXEL_NUM   = DEF_PIXEL_NUM,
    parameter int unsigned ACQ_NUM     = DEF_ACQ_NUM,
    parameter int unsigned NO_HIT_CODE = DEF_NO_HIT_CODE
) (
    input  logic                    clk,
    input  logic                    res,
    input  logic                    start,
    input  logic                    shot_valid,
    output logic                    shot_ready,
    input  logic [PIXEL_NUM-1:0]    hit_vld,
    input  logic [PIXEL_NUM*NP-1:0] hit_tof,
    output logic                    wrEn,
    output logic [NP-1:0]           data,
    output logic                    frame_done,
    output logic                    overrun,
    output logic                    busy
);

    localparam int unsigned PIX_W = (PIXEL_NUM > 1) ? $clog2(PIXEL_NUM) : 1;
    localparam int unsigned ACQ_W = $clog2(ACQ_NUM + 1);
    localparam logic [NP-1:0] NO_HIT   = NP'(NO_HIT_CODE);
    localparam logic [NP-1:0] MAX_CODE = '1;

    logic [1:0]             state, stateNext;
    logic [PIX_W-1:0]       pixCnt, pixNext;
    logic [ACQ_W-1:0]       acqCnt, acqNext;
    logic                   overrunNext;
    logic [PIXEL_NUM*NP-1:0] mappedShot;
    logic [NP-1:0]          rdData_c;
    logic                   streamFull, captureFull, streamFullNxt_c, captureFullNxt_c;
    logic                   lastPixel, shotDone, accept, loadStream, loadCapture, promote;

    // Map raw TDC results to stream codes at capture time
    always_comb begin
        for (int i = 0; i < PIXEL_NUM; i++) begin
            mappedShot[i*NP +: NP] = NP'(mapCode(hit_vld[i], 32'(hit_tof[i*NP +: NP]),
                                                 32'(NO_HIT), 32'(MAX_CODE)));
        end
    end

    // A full stream bank always emits; the shot ends on its last pixel
    assign lastPixel = (pixCnt == PIX_W'(PIXEL_NUM - 1));
    assign shotDone  = streamFull && lastPixel;
    assign accept    = shot_valid && shot_ready;
    // A shot goes straight to the stream bank if it is idle or freeing now
    assign loadStream  = accept && (!streamFull || (shotDone && !captureFull));
    assign loadCapture = accept && !loadStream;
    assign promote     = shotDone && captureFull;

    tdc_shot_buffer #(
        .NP        (NP),
        .PIXEL_NUM (PIXEL_NUM)
    ) u_buf (
        .clk              (clk),
        .res              (res),
        .loadStream       (loadStream),
        .loadCapture      (loadCapture),
        .promote          (promote),
        .retire           (shotDone),
        .shotIn           (mappedShot),
        .rdIdx            (pixCnt),
        .rdData_c         (rdData_c),
        .streamFull       (streamFull),
        .captureFull      (captureFull),
        .streamFullNxt_c  (streamFullNxt_c),
        .captureFullNxt_c (captureFullNxt_c)
    );

    // Next state and counters
    always_comb begin
        stateNext   = state;
        pixNext     = pixCnt;
        acqNext     = acqCnt;
        overrunNext = overrun;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    stateNext   = ST_ARM;
                    acqNext     = '0;
                    overrunNext = 1'b0;
                end
            end
            ST_ARM, ST_STREAM: begin
                if (streamFull) begin
                    stateNext = ST_STREAM;
                    pixNext   = lastPixel ? '0 : PIX_W'(pixCnt + 1'b1);
                    if (lastPixel) begin
                        acqNext = ACQ_W'(acqCnt + 1'b1);
                    end
                end else if (acqCnt == ACQ_W'(ACQ_NUM)) begin
                    stateNext = ST_DONE;
                end else begin
                    stateNext = ST_ARM;
                end
                if (shot_valid && !shot_ready) begin
                    overrunNext = 1'b1;
                end
            end
            ST_DONE: stateNext = ST_IDLE;
            default: stateNext = ST_IDLE;
        endcase
    end

    // State, counters and registered outputs
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state      <= ST_IDLE;
            pixCnt     <= '0;
            acqCnt     <= '0;
            wrEn       <= 1'b0;
            data       <= '0;
            shot_ready <= 1'b0;
            frame_done <= 1'b0;
            overrun    <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= stateNext;
            pixCnt     <= pixNext;
            acqCnt     <= acqNext;
            wrEn       <= streamFull;
            data       <= streamFull ? rdData_c : '0;
            // Ready while open, capture bank free and the frame not fully booked
            shot_ready <= ((stateNext == ST_ARM) || (stateNext == ST_STREAM)) && !captureFullNxt_c
                          && (({1'b0, acqNext} + (ACQ_W + 1)'(streamFullNxt_c)) < (ACQ_W + 1)'(ACQ_NUM));
            frame_done <= (stateNext == ST_DONE);
            overrun    <= overrunNext;
            busy       <= (stateNext != ST_IDLE);
        end
    end

endmodule

// File: tb/tb_tdc_stream_sequencer.sv
// Self-checking bench for tdc_stream_sequencer (NP=10, PIXEL_NUM=3, ACQ_NUM=2).
module tb_tdc_stream_sequencer;

    localparam int NP = 10;
    localparam int P  = 3;
    localparam int A  = 2;
    localparam int NOHIT = 0;

    logic          clk = 1'b0;
    logic          res;
    logic          start;
    logic          shot_valid;
    logic          shot_ready;
    logic [P-1:0]  hit_vld;
    logic [P*NP-1:0] hit_tof;
    logic          wrEn;
    logic [NP-1:0] data;
    logic          frame_done;
    logic          overrun;
    logic          busy;

    int checks = 0;
    int errors = 0;

    tdc_stream_sequencer #(
        .NP          (NP),
        .PIXEL_NUM   (P),
        .ACQ_NUM     (A),
        .NO_HIT_CODE (NOHIT)
    ) dut (
        .clk        (clk),
        .res        (res),
        .start      (start),
        .shot_valid (shot_valid),
        .shot_ready (shot_ready),
        .hit_vld    (hit_vld),
        .hit_tof    (hit_tof),
        .wrEn       (wrEn),
        .data       (data),
        .frame_done (frame_done),
        .overrun    (overrun),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // {wrEn, data, shot_ready, frame_done, overrun, busy}
    function automatic logic [14:0] pk(input logic w, input int d, input logic r,
                                       input logic f, input logic o, input logic b);
        return {w, 10'(d), r, f, o, b};
    endfunction

    function automatic logic [29:0] tofs(input int a, input int b, input int c);
        return {10'(c), 10'(b), 10'(a)};
    endfunction

    task automatic check(input string name, input logic [14:0] exp);
        logic [14:0] act;
        act = {wrEn, data, shot_ready, frame_done, overrun, busy};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got wr=%0b data=%0d rdy=%0b fd=%0b ov=%0b busy=%0b, want wr=%0b data=%0d rdy=%0b fd=%0b ov=%0b busy=%0b",
                     name, act[14], act[13:4], act[3], act[2], act[1], act[0],
                     exp[14], exp[13:4], exp[3], exp[2], exp[1], exp[0]);
        end
    endtask

    // Apply inputs for one rising edge, then land 1 time unit after it
    task automatic cyc(input logic st, input logic sv, input logic [P-1:0] hv, input logic [P*NP-1:0] tf);
        start = st; shot_valid = sv; hit_vld = hv; hit_tof = tf;
        @(posedge clk);
        #1;
        start = 1'b0; shot_valid = 1'b0; hit_vld = '0; hit_tof = '0;
    endtask

    // ---------------- reference model: beat queue per frame ----------------
    int  mPhase;          // 0 idle, 1 frame open, 2 frame-done cycle
    int  mQ[$];           // codes still to be streamed
    int  mAcc, mEmit;
    logic mRdy, mOv;

    task automatic modelReset();
        mPhase = 0; mQ.delete(); mAcc = 0; mEmit = 0; mRdy = 1'b0; mOv = 1'b0;
    endtask

    task automatic modelStep(input logic st, input logic sv, input logic [P-1:0] hv,
                             input logic [P*NP-1:0] tf, output logic [14:0] exp);
        logic w; int d; int t;
        w = 1'b0; d = 0;
        case (mPhase)
            0: if (st) begin mPhase = 1; mAcc = 0; mEmit = 0; mOv = 1'b0; end
            2: mPhase = 0;
            default: begin
                if (mQ.size() > 0) begin
                    w = 1'b1; d = mQ.pop_front(); mEmit++;
                end else if (mEmit == A*P) begin
                    mPhase = 2;
                end
                if (sv) begin
                    if (mRdy) begin
                        for (int i = 0; i < P; i++) begin
                            t = int'(tf[i*NP +: NP]);
                            mQ.push_back(!hv[i] ? NOHIT : (t == NOHIT ? NOHIT + 1 : t));
                        end
                        mAcc++;
                    end else begin
                        mOv = 1'b1;
                    end
                end
            end
        endcase
        mRdy = (mPhase == 1) && (mQ.size() <= P) && (mAcc < A);
        exp = pk(w, d, mRdy, mPhase == 2, mOv, mPhase != 0);
    endtask

    task automatic mcyc(input string name, input logic st, input logic sv,
                        input logic [P-1:0] hv, input logic [P*NP-1:0] tf);
        logic [14:0] exp;
        modelStep(st, sv, hv, tf, exp);
        cyc(st, sv, hv, tf);
        check(name, exp);
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic           st;
        logic           sv;
        logic [P-1:0]   hv;
        logic [P*NP-1:0] tf;
        logic [14:0]    exp;
    } vec_t;

    function automatic vec_t mk(input logic st, input logic sv, input logic [P-1:0] hv,
                                input logic [P*NP-1:0] tf, input logic [14:0] exp);
        vec_t v;
        v.st = st; v.sv = sv; v.hv = hv; v.tf = tf; v.exp = exp;
        return v;
    endfunction

    vec_t tbl [24];

    initial begin
        logic [P-1:0]    rhv;
        logic [P*NP-1:0] rtf;
        logic            rst_, rsv;

        res = 1'b0; start = 1'b0; shot_valid = 1'b0; hit_vld = '0; hit_tof = '0;

        // single full-hit shot, then a shot with no-hit / reserved-code pixels
        tbl[0]  = mk(1, 0, 3'b000, '0,                   pk(0, 0,    1, 0, 0, 1));
        tbl[1]  = mk(0, 1, 3'b111, tofs(108, 511, 1022), pk(0, 0,    1, 0, 0, 1));
        tbl[2]  = mk(0, 0, 3'b000, '0,                   pk(1, 108,  1, 0, 0, 1));
        tbl[3]  = mk(0, 0, 3'b000, '0,                   pk(1, 511,  1, 0, 0, 1));
        tbl[4]  = mk(0, 0, 3'b000, '0,                   pk(1, 1022, 1, 0, 0, 1));
        tbl[5]  = mk(0, 0, 3'b000, '0,                   pk(0, 0,    1, 0, 0, 1));
        tbl[6]  = mk(0, 1, 3'b010, tofs(5, 0, 7),        pk(0, 0,    0, 0, 0, 1));
        tbl[7]  = mk(0, 0, 3'b000, '0,                   pk(1, 0,    0, 0, 0, 1));
        tbl[8]  = mk(0, 0, 3'b000, '0,                   pk(1, 1,    0, 0, 0, 1));
        tbl[9]  = mk(0, 0, 3'b000, '0,                   pk(1, 0,    0, 0, 0, 1));
        tbl[10] = mk(0, 0, 3'b000, '0,                   pk(0, 0,    0, 1, 0, 1));
        tbl[11] = mk(0, 0, 3'b000, '0,                   pk(0, 0,    0, 0, 0, 0));
        // shot in IDLE ignored
        tbl[12] = mk(0, 1, 3'b111, tofs(1, 2, 3),        pk(0, 0,    0, 0, 0, 0));
        // back-to-back shots, overrun on a full capture bank, start while streaming
        tbl[13] = mk(1, 0, 3'b000, '0,                   pk(0, 0,    1, 0, 0, 1));
        tbl[14] = mk(0, 1, 3'b111, tofs(1, 2, 3),        pk(0, 0,    1, 0, 0, 1));
        tbl[15] = mk(0, 1, 3'b111, tofs(4, 5, 6),        pk(1, 1,    0, 0, 0, 1));
        tbl[16] = mk(1, 1, 3'b111, tofs(7, 8, 9),        pk(1, 2,    0, 0, 1, 1));
        tbl[17] = mk(0, 0, 3'b000, '0,                   pk(1, 3,    0, 0, 1, 1));
        tbl[18] = mk(0, 0, 3'b000, '0,                   pk(1, 4,    0, 0, 1, 1));
        tbl[19] = mk(0, 0, 3'b000, '0,                   pk(1, 5,    0, 0, 1, 1));
        tbl[20] = mk(0, 0, 3'b000, '0,                   pk(1, 6,    0, 0, 1, 1));
        tbl[21] = mk(0, 0, 3'b000, '0,                   pk(0, 0,    0, 1, 1, 1));
        tbl[22] = mk(0, 0, 3'b000, '0,                   pk(0, 0,    0, 0, 1, 0));
        tbl[23] = mk(1, 0, 3'b000, '0,                   pk(0, 0,    1, 0, 0, 1));

        // reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", pk(0, 0, 0, 0, 0, 0));
        res = 1'b1;

        for (int i = 0; i < 24; i++) begin
            cyc(tbl[i].st, tbl[i].sv, tbl[i].hv, tbl[i].tf);
            check($sformatf("vec%0d", i), tbl[i].exp);
        end

        // asynchronous reset in the middle of a shot
        cyc(0, 1, 3'b111, tofs(10, 20, 30));
        check("mid_accept", pk(0, 0, 1, 0, 0, 1));
        cyc(0, 0, '0, '0);
        check("mid_beat1", pk(1, 10, 1, 0, 0, 1));
        cyc(0, 0, '0, '0);
        check("mid_beat2", pk(1, 20, 1, 0, 0, 1));
        #2 res = 1'b0;
        #1 check("async_reset", pk(0, 0, 0, 0, 0, 0));
        @(posedge clk);
        #1 check("reset_hold", pk(0, 0, 0, 0, 0, 0));
        res = 1'b1;

        // normal frame after reset, then randomized traffic, both against the model
        modelReset();
        mcyc("post_rst_start", 1, 0, '0, '0);
        mcyc("post_rst_shot1", 0, 1, 3'b101, tofs(0, 300, 1023));
        mcyc("post_rst_shot2", 0, 1, 3'b111, tofs(17, 0, 900));
        for (int i = 0; i < 10; i++) begin
            mcyc($sformatf("post_rst_run%0d", i), 0, 0, '0, '0);
        end

        for (int i = 0; i < 800; i++) begin
            rst_ = (mPhase == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 15) == 0);
            rsv  = ($urandom_range(0, 1) == 1);
            rhv  = P'($urandom_range(0, (1 << P) - 1));
            for (int p = 0; p < P; p++) begin
                rtf[p*NP +: NP] = ($urandom_range(0, 3) == 0) ? 10'd0 : 10'($urandom_range(0, 1023));
            end
            mcyc($sformatf("rand%0d", i), rst_, rsv, rhv, rtf);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tdc_stream_sequencer.md
Name: tdc_stream_sequencer

Overview:
- Transmit side of the pixel-serial histogram write stream (wrEn/data) consumed by the histogram builder FSM.
- Captures one laser shot's per-pixel TDC results from the pixel array in parallel.
- Double-buffers each shot and emits it as one NP-bit code per cycle, in pixel order, for ACQ_NUM shots per frame.
- Fixed slot timing keeps the builder's internal pixel/acquisition counters aligned with no side-band signalling.

Parameters:
- NP, 10, timestamp/code width (matches builder data width)
- PIXEL_NUM, 6, pixels per shot; beats per shot
- ACQ_NUM, 4, shots per frame
- NO_HIT_CODE, 0, code emitted for a pixel with no photon

Ports:
- clk  in  1  system clock
- res  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; arms a new frame
- shot_valid  in  1  parallel shot data present this cycle
- shot_ready  out  1  capture buffer can accept a shot
- hit_vld  in  PIXEL_NUM  per-pixel photon-detected flag
- hit_tof  in  PIXEL_NUM*NP  per-pixel timestamp; pixel i at [i*NP +: NP]
- wrEn  out  1  stream beat valid to histogram builder
- data  out  NP  stream code
- frame_done  out  1  one-cycle pulse after last beat of frame
- overrun  out  1  sticky: shot dropped while shot_ready=0
- busy  out  1  high in any state except IDLE

Behaviour:
- Reset (res=0, async): state IDLE; wrEn=0, data=0, shot_ready=0, frame_done=0, overrun=0, busy=0; pixel/acq counters=0; both banks empty.
- States: IDLE, ARM (frame open, no beat this cycle), STREAM (emitting beats), DONE (1 cycle, frame_done=1) -> IDLE.
- IDLE: start=1 -> ARM; clears acq_cnt and overrun. Shots are ignored in IDLE (shot_ready=0, overrun not set).
- start outside IDLE is ignored.
- shot_ready = frame open (ARM/STREAM) AND capture bank empty. A shot is accepted when shot_valid && shot_ready at a rising edge.
- Code mapping per pixel:
  - hit_vld=0 -> NO_HIT_CODE.
  - hit_vld=1 and tof==NO_HIT_CODE -> NO_HIT_CODE+1 (saturating; reserves the no-hit code).
  - Otherwise tof unchanged.
- Latency: a shot accepted at edge k with the stream bank idle is loaded directly into the stream bank. Pixel 0 appears with wrEn=1 after edge k+1; pixels 1..PIXEL_NUM-1 follow on consecutive cycles; wrEn stays high for exactly PIXEL_NUM cycles.
- Back-to-back shots: a shot accepted while streaming is held in the capture bank. At the edge that emits the last pixel of the current shot, it is promoted to the stream bank; its pixel 0 follows with no bubble. The capture bank frees at that edge, so shot_ready rises the next cycle.
- Simultaneous accept and promote in the same edge is legal; the capture bank is refilled, not lost.
- When wrEn=0, data=0.
- acq_cnt increments after the last beat of each shot.
  - If the next shot is not yet available: STREAM -> ARM.
  - When acq_cnt reaches ACQ_NUM: -> DONE. frame_done=1 for one cycle immediately after the final beat; shot_ready=0 from that cycle on.
- Extra shots beyond ACQ_NUM are never accepted; in DONE/IDLE shot_ready=0.
- shot_valid while shot_ready=0 in ARM/STREAM: shot dropped, overrun set (sticky until the next accepted start or reset). The stream is unaffected.
- Reset mid-frame: all outputs return to reset values immediately; a partial shot is discarded. The builder is reset on the same res net.
- Counters: pix_cnt is ceil(log2(PIXEL_NUM)) wide and wraps at PIXEL_NUM-1; acq_cnt is ceil(log2(ACQ_NUM+1)) wide.

Decomposition:
- Shared package: NP, PIXEL_NUM, ACQ_NUM, NO_HIT_CODE defaults; the state enum {IDLE, ARM, STREAM, DONE}; the code-mapping function.
- One sub-module, tdc_shot_buffer: two-entry (capture + stream) pixel-bank store with load/promote/empty flags and a pixel-indexed read mux.
- FSM and counters stay in tdc_stream_sequencer.

Test Plan (NP=10, PIXEL_NUM=3, ACQ_NUM=2):
- Reset then start; one shot with hit_vld=3'b111, tofs {108,511,1022} at edge k -> wrEn high edges k+1..k+3 with data 108, 511, 1022; wrEn=0, data=0 at k+4; no frame_done.
- Shot with hit_vld=3'b010, tofs {5,0,7} -> data 0, 1, 0 (no-hit code, then reserved-code bump).
- Two shots presented on consecutive ready cycles -> 6 contiguous wrEn beats with no bubble; frame_done pulses once, the cycle after beat 6; busy falls the following cycle.
- Third shot_valid while capture bank full -> shot dropped, overrun=1, stream contents unchanged; the next start clears overrun.
- Assert res low during beat 2 of shot 1 -> wrEn, data, busy go 0 asynchronously. After release, start plus 2 shots yields a normal 6-beat frame.
- shot_valid in IDLE, and start while in STREAM -> both ignored: no beats, overrun stays 0, acq_cnt undisturbed.
